// File: rtl/ps2_kbd_pkg.sv
// Shared constants, receiver state encoding and helper functions for the
// PS/2 keyboard front end and its voice allocator.
package ps2_kbd_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SLOT_FREE = 8'hF0;

    localparam int NUM_PLAYABLE = 20;

    // Scan codes that map to notes on the synthesizer keyboard.
    localparam logic [7:0] PLAYABLE_KEYS [NUM_PLAYABLE] = '{
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C,
        8'h52, 8'h5B, 8'h4D, 8'h44, 8'h43, 8'h35, 8'h2C, 8'h24, 8'h1D, 8'h15
    };

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    // True when the code belongs to the playable-key table.
    function automatic logic is_playable(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_PLAYABLE; i++) begin
            hit = hit | (PLAYABLE_KEYS[i] == code);
        end
        return hit;
    endfunction

    // PS/2 uses odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: input synchronisers, falling-edge
// detection, start/data/parity/stop framing and an inter-edge timeout.
module ps2_rx_frame #(
    parameter int CLK_HZ     = 50000000,
    parameter int TIMEOUT_US = 2000
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);
    import ps2_kbd_pkg::*;

    localparam int TMO_CYC = (CLK_HZ / 1000000) * TIMEOUT_US;
    localparam int TMO_W   = $clog2(TMO_CYC + 1);

    logic             clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_s3_q, clk_s3_d;
    logic             dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    rx_state_e        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             scan_valid_q, scan_valid_d;
    logic [7:0]       scan_code_q, scan_code_d;
    logic             frame_err_q, frame_err_d;
    logic             fall_s;
    logic             tmo_expire_s;

    // Falling edge of the synchronised PS/2 clock, masked during the init window.
    assign fall_s       = rx_en & clk_s3_q & ~clk_s2_q;
    assign tmo_expire_s = (state_q != RX_IDLE) && !fall_s && (tmo_q == TMO_W'(TMO_CYC - 1));

    // Next-state logic: synchronisers, frame FSM, timeout and result pulses.
    always_comb begin
        clk_s1_d     = ps2_clk;
        clk_s2_d     = clk_s1_q;
        clk_s3_d     = clk_s2_q;
        dat_s1_d     = ps2_dat;
        dat_s2_d     = dat_s1_q;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        scan_code_d  = scan_code_q;
        scan_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q == RX_IDLE || fall_s) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            RX_IDLE: begin
                if (fall_s && !dat_s2_q) begin
                    state_d   = RX_DATA;
                    bit_cnt_d = 3'd0;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (fall_s) begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    state_d = RX_DATA;
                end
            end
            RX_PARITY: begin
                if (fall_s) begin
                    par_d   = dat_s2_q;
                    state_d = RX_STOP;
                end else begin
                    state_d = RX_PARITY;
                end
            end
            RX_STOP: begin
                if (fall_s) begin
                    state_d = RX_IDLE;
                    if (dat_s2_q && odd_parity_ok(shift_q, par_q)) begin
                        scan_valid_d = 1'b1;
                        scan_code_d  = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    state_d = RX_STOP;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        // A stalled frame is abandoned; partial data is simply left unused.
        if (tmo_expire_s) begin
            state_d     = RX_IDLE;
            frame_err_d = 1'b1;
        end else begin
            frame_err_d = frame_err_d;
        end
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            clk_s3_q     <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            state_q      <= RX_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            scan_valid_q <= 1'b0;
            scan_code_q  <= 8'h00;
            frame_err_q  <= 1'b0;
        end else begin
            clk_s1_q     <= clk_s1_d;
            clk_s2_q     <= clk_s2_d;
            clk_s3_q     <= clk_s3_d;
            dat_s1_q     <= dat_s1_d;
            dat_s2_q     <= dat_s2_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            scan_valid_q <= scan_valid_d;
            scan_code_q  <= scan_code_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign scan_valid = scan_valid_q;
    assign scan_code  = scan_code_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_voice_alloc.sv
// PS/2 keyboard front end: frame receiver plus make/break decoding that
// assigns held playable keys to the lowest free voice slot.
module ps2_key_voice_alloc #(
    parameter int NUM_VOICES  = 4,
    parameter int CLK_HZ      = 50000000,
    parameter int TIMEOUT_US  = 2000,
    parameter int INIT_CYCLES = 500
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    ps2_clk,
    input  logic                    ps2_dat,
    input  logic                    clear_n,
    output logic                    scan_valid,
    output logic [7:0]              scan_code,
    output logic                    frame_err,
    output logic [NUM_VOICES-1:0]   voice_on,
    output logic [8*NUM_VOICES-1:0] voice_code,
    output logic                    overflow
);
    import ps2_kbd_pkg::*;

    localparam int INIT_W = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;

    logic [INIT_W-1:0]             init_q, init_d;
    logic                          rx_en_s;
    logic                          ext_q, ext_d, brk_q, brk_d;
    logic                          ovf_q, ovf_d;
    logic [NUM_VOICES-1:0]         von_q, von_d;
    logic [NUM_VOICES-1:0][7:0]    vcode_q, vcode_d;
    logic [NUM_VOICES-1:0]         match_s, free_s, alloc_oh_s;

    assign rx_en_s = (init_q == INIT_W'(INIT_CYCLES));

    ps2_rx_frame #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TIMEOUT_US)
    ) u_rx (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .rx_en      (rx_en_s),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .frame_err  (frame_err)
    );

    // Init counter saturates once the receiver is allowed to listen.
    always_comb begin
        if (rx_en_s) begin
            init_d = init_q;
        end else begin
            init_d = init_q + INIT_W'(1);
        end
    end

    // Slot lookup: which slots hold the current code, which are free, lowest free.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            match_s[i] = von_q[i] && (vcode_q[i] == scan_code);
            free_s[i]  = ~von_q[i];
        end
        alloc_oh_s = free_s & (~free_s + NUM_VOICES'(1));
    end

    // Prefix tracking and slot allocate/free; clear_n overrides any decode.
    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        von_d   = von_q;
        vcode_d = vcode_q;
        ovf_d   = 1'b0;

        if (!clear_n) begin
            ext_d   = 1'b0;
            brk_d   = 1'b0;
            von_d   = '0;
            vcode_d = {NUM_VOICES{SLOT_FREE}};
        end else if (scan_valid) begin
            case (scan_code)
                SC_EXT: begin
                    ext_d = 1'b1;
                end
                SC_BREAK: begin
                    brk_d = 1'b1;
                end
                default: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    if (ext_q) begin
                        ovf_d = 1'b0;
                    end else if (brk_q) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (match_s[i]) begin
                                von_d[i]   = 1'b0;
                                vcode_d[i] = SLOT_FREE;
                            end else begin
                                von_d[i] = von_d[i];
                            end
                        end
                    end else if (is_playable(scan_code) && (match_s == '0)) begin
                        if (free_s != '0) begin
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (alloc_oh_s[i]) begin
                                    von_d[i]   = 1'b1;
                                    vcode_d[i] = scan_code;
                                end else begin
                                    von_d[i] = von_d[i];
                                end
                            end
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        ovf_d = 1'b0;
                    end
                end
            endcase
        end else begin
            ovf_d = 1'b0;
        end
    end

    // Decoder and init-counter registers.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            init_q  <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            ovf_q   <= 1'b0;
            von_q   <= '0;
            vcode_q <= {NUM_VOICES{SLOT_FREE}};
        end else begin
            init_q  <= init_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            ovf_q   <= ovf_d;
            von_q   <= von_d;
            vcode_q <= vcode_d;
        end
    end

    assign voice_on   = von_q;
    assign voice_code = vcode_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_key_voice_alloc.sv
// Self-checking bench for ps2_key_voice_alloc: directed scenarios followed by
// a random key stream, compared against an event-level keyboard model.
module tb_ps2_key_voice_alloc;

    localparam int NV     = 4;
    localparam int CLKHZ  = 1000000;
    localparam int TMO_US = 200;
    localparam int INIT   = 50;
    localparam int HALF   = 8;

    logic            sys_clk = 1'b0;
    logic            reset   = 1'b0;
    logic            ps2_clk = 1'b1;
    logic            ps2_dat = 1'b1;
    logic            clear_n = 1'b1;
    logic            scan_valid;
    logic [7:0]      scan_code;
    logic            frame_err;
    logic [NV-1:0]   voice_on;
    logic [8*NV-1:0] voice_code;
    logic            overflow;

    ps2_key_voice_alloc #(
        .NUM_VOICES  (NV),
        .CLK_HZ      (CLKHZ),
        .TIMEOUT_US  (TMO_US),
        .INIT_CYCLES (INIT)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .clear_n    (clear_n),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .frame_err  (frame_err),
        .voice_on   (voice_on),
        .voice_code (voice_code),
        .overflow   (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int compared   = 0;
    int mismatched = 0;

    // Pulse counters observed from the DUT.
    int sv_cnt  = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;

    always @(posedge sys_clk) begin
        if (scan_valid) sv_cnt <= sv_cnt + 1;
        if (frame_err)  err_cnt <= err_cnt + 1;
        if (overflow)   ovf_cnt <= ovf_cnt + 1;
    end

    // Reference model: a list of held keys per slot plus prefix flags.
    bit         m_on [NV];
    logic [7:0] m_code [NV];
    bit         m_ext, m_brk;
    int         exp_sv, exp_err, exp_ovf;
    logic [7:0] exp_code;
    logic [7:0] keys [20] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42,
                              8'h4B, 8'h4C, 8'h52, 8'h5B, 8'h4D, 8'h44, 8'h43, 8'h35,
                              8'h2C, 8'h24, 8'h1D, 8'h15};

    function automatic bit playable(input logic [7:0] c);
        return c inside {8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C,
                         8'h52, 8'h5B, 8'h4D, 8'h44, 8'h43, 8'h35, 8'h2C, 8'h24, 8'h1D, 8'h15};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NV; i++) begin
            m_on[i]   = 1'b0;
            m_code[i] = 8'hF0;
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic model_key(input logic [7:0] c);
        bit held;
        bit placed;
        exp_sv++;
        exp_code = c;
        if (c == 8'hE0) begin
            m_ext = 1'b1;
        end else if (c == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (!m_ext) begin
                held = 1'b0;
                for (int i = 0; i < NV; i++) if (m_on[i] && m_code[i] == c) held = 1'b1;
                if (m_brk) begin
                    for (int i = 0; i < NV; i++) begin
                        if (m_on[i] && m_code[i] == c) begin
                            m_on[i]   = 1'b0;
                            m_code[i] = 8'hF0;
                        end
                    end
                end else if (playable(c) && !held) begin
                    placed = 1'b0;
                    for (int i = 0; i < NV; i++) begin
                        if (!placed && !m_on[i]) begin
                            m_on[i]   = 1'b1;
                            m_code[i] = c;
                            placed    = 1'b1;
                        end
                    end
                    if (!placed) exp_ovf++;
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [NV-1:0]   e_on;
        logic [8*NV-1:0] e_vc;
        for (int i = 0; i < NV; i++) begin
            e_on[i]          = m_on[i];
            e_vc[i*8 +: 8]   = m_on[i] ? m_code[i] : 8'hF0;
        end
        chk({tag, "/voice_on"},   64'(voice_on),   64'(e_on));
        chk({tag, "/voice_code"}, 64'(voice_code), 64'(e_vc));
        chk({tag, "/scan_cnt"},   64'(sv_cnt),     64'(exp_sv));
        chk({tag, "/err_cnt"},    64'(err_cnt),    64'(exp_err));
        chk({tag, "/ovf_cnt"},    64'(ovf_cnt),    64'(exp_ovf));
        chk({tag, "/scan_code"},  64'(scan_code),  64'(exp_code));
    endtask

    // Drive nedges bits of a frame: start, 8 data LSB first, parity, stop.
    task automatic send_frame(input logic [7:0] code, input bit bad_par,
                              input bit stop_bit, input int nedges);
        logic [10:0] bits;
        bits = {stop_bit, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nedges; i++) begin
            ps2_dat = bits[i];
            repeat (HALF) @(posedge sys_clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge sys_clk);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (HALF) @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic good(input logic [7:0] code);
        send_frame(code, 1'b0, 1'b1, 11);
        model_key(code);
    endtask

    task automatic do_clear();
        @(negedge sys_clk);
        clear_n = 1'b0;
        @(negedge sys_clk);
        clear_n = 1'b1;
        model_clear();
        @(negedge sys_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "/scan_valid"}, 64'(scan_valid), 64'(0));
        chk({tag, "/scan_code"},  64'(scan_code),  64'(0));
        chk({tag, "/frame_err"},  64'(frame_err),  64'(0));
        chk({tag, "/overflow"},   64'(overflow),   64'(0));
        chk({tag, "/voice_on"},   64'(voice_on),   64'(0));
        chk({tag, "/voice_code"}, 64'(voice_code), 64'(32'hF0F0F0F0));
    endtask

    initial begin
        int r;
        logic [7:0] c;
        model_clear();
        exp_sv = 0; exp_err = 0; exp_ovf = 0; exp_code = 8'h00;

        // Reset values.
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("reset");

        // Edges inside the init window must be ignored.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ps2_dat = 1'b0;
            repeat (4) @(posedge sys_clk);
            ps2_clk = 1'b0;
            repeat (4) @(posedge sys_clk);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (INIT + 20) @(negedge sys_clk);
        check_all("init_quiet");

        // First good frame allocates slot 0.
        good(8'h1C);
        check_all("first_1C");

        // Fill all slots, fifth key overflows.
        good(8'h1B); good(8'h23); good(8'h2B);
        check_all("fill4");
        good(8'h34);
        check_all("overflow_34");
        chk("overflow_total", 64'(ovf_cnt), 64'(1));

        // Free slot 0 with a break and reuse it.
        do_clear();
        check_all("clear1");
        good(8'h1C); good(8'h1B);
        good(8'hF0); good(8'h1C);
        check_all("break_1C");
        chk("break_von", 64'(voice_on), 64'(4'b0010));
        good(8'h42);
        check_all("reuse_42");
        chk("reuse_vc", 64'(voice_code[15:0]), 64'(16'h1B42));

        // Parity error, stop-bit error, then a stalled partial frame.
        send_frame(8'h1C, 1'b1, 1'b1, 11); exp_err++;
        check_all("bad_parity");
        send_frame(8'h1C, 1'b0, 1'b0, 11); exp_err++;
        check_all("bad_stop");
        send_frame(8'h1C, 1'b0, 1'b1, 5);
        repeat (TMO_US * 3 / 2) @(negedge sys_clk);
        exp_err++;
        check_all("timeout");
        good(8'h23);
        check_all("after_errors");

        // Extended keys ignored, typematic repeat held once, clear frees all.
        do_clear();
        good(8'hE0); good(8'h1C);
        check_all("ext_ignored");
        good(8'h1C); good(8'h1C);
        check_all("repeat_1C");
        chk("repeat_von", 64'(voice_on), 64'(4'b0001));
        do_clear();
        check_all("clear2");

        // Random key stream against the model.
        for (int n = 0; n < 70; n++) begin
            r = $urandom_range(0, 99);
            if (r < 6) begin
                do_clear();
            end else if (r < 10) begin
                c = keys[$urandom_range(0, 19)];
                send_frame(c, 1'b1, 1'b1, 11);
                exp_err++;
            end else begin
                r = $urandom_range(0, 99);
                if (r < 22)      c = 8'hF0;
                else if (r < 27) c = 8'hE0;
                else if (r < 32) c = 8'h5A;
                else             c = keys[$urandom_range(0, 19)];
                good(c);
            end
            check_all($sformatf("rand%0d", n));
        end

        // Reset in the middle of a frame, then a fresh frame after init.
        send_frame(8'h2B, 1'b0, 1'b1, 4);
        reset = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("mid_reset");
        model_clear();
        exp_code = 8'h00;
        reset = 1'b1;
        repeat (INIT + 10) @(negedge sys_clk);
        good(8'h1C);
        check_all("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ps2_key_voice_alloc.md
Name: ps2_key_voice_alloc

Overview:
- Parametrised successor to the single-pair PS/2 keyboard front end, fully synchronous to sys_clk.
- Receives PS/2 device-to-host frames, checks start, parity and stop bits, and reports every good scan code.
- Tracks make/break codes of playable keys and allocates them to NUM_VOICES voice slots (lowest free slot first).
- Sits between the PS/2 pins and the synthesizer tone generators.

Parameters:
- NUM_VOICES, 4, number of simultaneously held playable keys (1..8).
- CLK_HZ, 50000000, sys_clk frequency.
- TIMEOUT_US, 2000, maximum gap between PS/2 clock falling edges inside a frame before the frame is abandoned.
- INIT_CYCLES, 500, sys_clk cycles after reset release during which the receiver ignores the bus.

Ports:
- sys_clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock, asynchronous
- ps2_dat  in  1  raw PS/2 data, asynchronous; receive-only, the block never drives the line
- clear_n  in  1  synchronous active-low voice clear
- scan_valid  out  1  one-cycle pulse per good frame
- scan_code  out  8  last good code; held between pulses
- frame_err  out  1  one-cycle pulse on parity, stop-bit or timeout error
- voice_on  out  NUM_VOICES  slot i holds a key
- voice_code  out  8*NUM_VOICES  slot i code in bits [8i+7:8i]; 8'hF0 when the slot is free
- overflow  out  1  one-cycle pulse when a playable make finds no free slot

Behaviour:
- Reset values (reset=0, asynchronous): all outputs 0, except every voice_code slot = 8'hF0. Internal break/extended flags cleared, FSM in IDLE, init counter 0.
- Input synchronisation: ps2_clk and ps2_dat each pass through a 2-FF synchroniser. A falling edge is detected on the synchronised clock. All sampling happens on that edge-detect cycle.
- Init window: falling edges are ignored until the init counter reaches INIT_CYCLES. The counter saturates there.
- Frame FSM:
  - IDLE: on an edge with data=0 (start bit), go to DATA, bit counter=0. An edge with data=1 stays in IDLE.
  - DATA: shift in 8 bits, LSB first; after bit 7, go to PARITY.
  - PARITY: capture the bit; go to STOP.
  - STOP: frame is good only if data=1 and the 9 bits (data + parity) have odd parity. If good, pulse scan_valid on the next cycle with scan_code updated on the same cycle. Otherwise pulse frame_err. Return to IDLE.
- Timeout: a counter of CLK_HZ/1e6*TIMEOUT_US cycles clears on every edge and runs while not in IDLE. On expiry, pulse frame_err and go to IDLE. Any partial data is discarded.
- Decoder, acting one cycle after scan_valid, i.e. voice outputs change 2 cycles after the stop-bit edge:
  - 8'hE0 sets the extended flag.
  - 8'hF0 sets the break flag.
  - Any other code: if extended is set, the code is ignored for voices. Otherwise, with break set, a slot holding the code is freed (voice_on=0, code=F0). A break for an unheld code does nothing. Without break, a playable code already held does nothing (typematic repeat). A playable code not held goes to the lowest-index free slot. If no slot is free, pulse overflow and change nothing.
  - Both flags clear after any non-prefix code.
- A code is never held in two slots.
- clear_n=0: all slots are freed and the flags cleared on that clock. Frame reception continues. clear_n has priority over a simultaneous decode.
- Reset mid-frame: everything returns to reset values. The next frame must start with a fresh start bit.

Decomposition:
- Package ps2_kbd_pkg holds:
  - constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SLOT_FREE=8'hF0;
  - the 20-entry playable-key table (1C 1B 23 2B 34 33 3B 42 4B 4C 52 5B 4D 44 43 35 2C 24 1D 15);
  - function is_playable(code).
- One sub-module, ps2_rx_frame: synchroniser, edge detect, frame FSM and timeout. It outputs scan_valid, scan_code and frame_err. The top level holds the init counter, decoder and slot array.

Test Plan:
- Frame 8'h1C with correct parity 0 and stop 1 → scan_valid pulses once with scan_code=1C; voice_on=0001, slot0=1C.
- Sequence 1C, 1B, 23, 2B, 34 (NUM_VOICES=4) → slots 1C/1B/23/2B, voice_on=1111, one overflow pulse on 34.
- With 1C and 1B held: send F0,1C then 42 → slot0 freed then reused, slot0=42, slot1=1B.
- Frame 1C with wrong parity; then a frame with stop=0; then 5 bits followed by a 3 ms idle gap → three frame_err pulses, no scan_valid, voices unchanged. The next good frame is decoded normally.
- Send E0,1C; send 1C twice; assert clear_n → E0,1C ignored; the 1C repeat occupies only slot0; clear_n frees all slots to F0.
- Edges during the first INIT_CYCLES after reset, then a good frame → only the post-init frame is reported.
